mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the CPU data port.
- Arbitrates each cycle and drives the SRAM.
- Returns read data or write acknowledges with a one-cycle valid pulse.
- Sits between the CPU core (fetch: rom_addr/rom_data; data: mem_addr/mem_r/mem_w/mem_din/mem_dout) and the unified memory macro.

Parameters:
XLEN, 32, data/address width; BYTES = XLEN/8 byte lanes
WORDS_LOG2, 12, SRAM depth = 2**WORDS_LOG2 words

Ports:
clk  in  1  clock; all state updates on rising edge
rstl  in  1  reset; asynchronous, active-high (asserted = 1)
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  XLEN  fetch byte address; word aligned
if_rdata  out  XLEN  fetched instruction word
if_valid  out  1  one-cycle pulse: fetch complete
d_req  in  1  data request; held with d_addr/d_r/d_w/d_wdata stable until d_valid
d_addr  in  XLEN  data byte address; low log2(BYTES) bits ignored
d_r  in  BYTES  byte-lane read strobes
d_w  in  BYTES  byte-lane write strobes
d_wdata  in  XLEN  write data, lane-aligned
d_rdata  out  XLEN  read data, all lanes
d_valid  out  1  one-cycle pulse: data access complete
sram_en  out  1  SRAM access this cycle
sram_we  out  BYTES  SRAM byte write enables
sram_addr  out  WORDS_LOG2  SRAM word address = addr[WORDS_LOG2+log2(BYTES)-1 : log2(BYTES)]
sram_wdata  out  XLEN  SRAM write data
sram_rdata  in  XLEN  SRAM read data; valid the cycle after sram_en

Behaviour:
- Reset values:
  - if_valid = 0, d_valid = 0.
  - if_rdata = 0, d_rdata = 0.
  - pend = NONE.
  - sram_en = 0, sram_we = 0.
- In-flight state pend ∈ {NONE, IF, D}, registered. It records which port was issued last cycle.
- Eligibility in cycle T:
  - Fetch is eligible if if_req = 1 and pend ≠ IF.
  - Data is eligible if d_req = 1, (d_r | d_w) ≠ 0, and pend ≠ D.
  - The port completing in T is not eligible, because its req still belongs to the finished transaction.
- Grant is combinational in cycle T:
  - Data has fixed priority over fetch.
  - The winner drives sram_en = 1, sram_addr and sram_we (d_w for data, 0 for fetch), and sram_wdata = d_wdata.
  - No winner: sram_en = 0, sram_we = 0.
- Next-state logic: pend ← winner, or NONE if there is no winner.
- Completion in T+1, when pend = X:
  - X_valid = 1 for exactly one cycle.
  - X_rdata = sram_rdata combinationally during the valid cycle.
  - The same value is captured into a hold register, and X_rdata = held value in all later cycles.
- Writes: d_valid still pulses at T+1. d_rdata is updated with sram_rdata; its value is don't-care.
- d_r and d_w both nonzero: treated as a write; d_rdata don't-care.
- Throughput:
  - Alternating ports reach 1 access/cycle.
  - A single port gets 1 access per 2 cycles.
  - Fetch cannot starve: data is ineligible in its completion cycle.
- Latency: 1 cycle from grant to valid, minimum. Waiting cycles add when the other port wins.
- Reset asserted mid-operation:
  - Valids and pend clear immediately.
  - An in-flight read result is dropped.
  - A write already clocked into the SRAM remains.
  - Requesters must re-issue after reset.
- req deasserted before valid: protocol violation. Behaviour is don't-care, and the arbiter still pulses valid if the request was issued.

Optional Feature:
Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_if_wait (32) and stat_d_wait (32), both reset to 0.
  - Each counts cycles where its port had req = 1, was not in its completion cycle, and was not granted.
  - Counters saturate at 2**32-1.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Fetch-only: if_req = 1, if_addr = 0x8; SRAM word 2 = 0x00A00093 -> sram_en and sram_addr = 2 at T; if_valid at T+1 with if_rdata = 0x00A00093; next grant at T+2.
- Data write then read:
  - d_w = 4'b0011, d_addr = 0x10, d_wdata = 0x0000FC18 -> sram_we = 0011, sram_addr = 4, d_valid at T+1.
  - Then d_r = 4'b1111 at the same address -> d_rdata[15:0] = 0xFC18.
- Contention: if_req and d_req both rise at T -> data granted at T, fetch at T+1; d_valid at T+1, if_valid at T+2.
- Ping-pong: both held continuously for 8 cycles -> sram_en = 1 every cycle, 4 grants per port, strict alternation.
- Reset during a read: rstl = 1 the cycle after a fetch grant -> if_valid stays 0 and if_rdata = 0; after release, re-issued fetch completes normally.
- MEM_ARB_STATS_EN: run the contention case -> stat_if_wait = 1, stat_d_wait = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous SRAM between the CPU instruction-fetch
//   port and the CPU data port. The data port has fixed priority. A port that
//   has just been issued is ineligible in its completion cycle, so two active
//   ports strictly alternate and fetch can never starve.
//
// Optional build macro: MEM_ARB_STATS_EN
//   Adds 32-bit saturating wait counters stat_if_wait / stat_d_wait.
//
// Ports
//   clk, rstl            clock, asynchronous active-high reset
//   if_req/if_addr       fetch request and byte address (word aligned)
//   if_rdata/if_valid    fetched word, one-cycle completion pulse
//   d_req/d_addr         data request and byte address
//   d_r/d_w/d_wdata      byte-lane read/write strobes, lane-aligned write data
//   d_rdata/d_valid      read data, one-cycle completion pulse
//   sram_*               single-port SRAM interface (1-cycle read latency)
//   stat_if_wait/stat_d_wait (MEM_ARB_STATS_EN only) wait-cycle counters

module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int WORDS_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rstl,
  input  logic                  if_req,
  input  logic [XLEN-1:0]       if_addr,
  output logic [XLEN-1:0]       if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic [XLEN-1:0]       d_addr,
  input  logic [XLEN/8-1:0]     d_r,
  input  logic [XLEN/8-1:0]     d_w,
  input  logic [XLEN-1:0]       d_wdata,
  output logic [XLEN-1:0]       d_rdata,
  output logic                  d_valid,
  output logic                  sram_en,
  output logic [XLEN/8-1:0]     sram_we,
  output logic [WORDS_LOG2-1:0] sram_addr,
  output logic [XLEN-1:0]       sram_wdata,
  input  logic [XLEN-1:0]       sram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_if_wait,
  output logic [31:0]           stat_d_wait
`endif
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF   = $clog2(BYTES);

  // Which port was issued to the SRAM last cycle (i.e. completes this cycle).
  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_IF   = 2'd1;
  localparam logic [1:0] PEND_D    = 2'd2;

  logic [1:0]      pend;
  logic            if_elig;
  logic            d_elig;
  logic            grant_if;
  logic            grant_d;
  logic [XLEN-1:0] if_hold;
  logic [XLEN-1:0] d_hold;

  // Address bits below word granularity and above the SRAM depth are unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[OFF-1:0], if_addr[XLEN-1:WORDS_LOG2+OFF],
                              d_addr[OFF-1:0], d_addr[XLEN-1:WORDS_LOG2+OFF]};

  // A port whose transaction completes this cycle still holds its req for
  // that finished transaction, so it must not be granted again. Nothing is
  // issued while reset is held so the SRAM sees no stray access.
  always_comb begin
    if_elig  = 1'b0;
    d_elig   = 1'b0;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!rstl) begin
      if_elig  = if_req && (pend != PEND_IF);
      d_elig   = d_req && ((d_r | d_w) != '0) && (pend != PEND_D);
      grant_d  = d_elig;
      grant_if = if_elig && !d_elig;
    end
  end

  // SRAM drive: the winner supplies address and byte enables. Write data is
  // always the data port's, since fetch never writes.
  always_comb begin
    sram_en    = grant_d || grant_if;
    sram_we    = '0;
    sram_addr  = if_addr[WORDS_LOG2+OFF-1:OFF];
    sram_wdata = d_wdata;
    if (grant_d) begin
      sram_we   = d_w;
      sram_addr = d_addr[WORDS_LOG2+OFF-1:OFF];
    end
  end

  // Track the port issued this cycle so its completion can be signalled.
  always_ff @(posedge clk or posedge rstl) begin
    if (rstl) begin
      pend <= PEND_NONE;
    end else if (grant_d) begin
      pend <= PEND_D;
    end else if (grant_if) begin
      pend <= PEND_IF;
    end else begin
      pend <= PEND_NONE;
    end
  end

  // Capture the completing read so the port keeps seeing it afterwards.
  always_ff @(posedge clk or posedge rstl) begin
    if (rstl) begin
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      if (pend == PEND_IF) if_hold <= sram_rdata;
      if (pend == PEND_D)  d_hold  <= sram_rdata;
    end
  end

  // Valid is the completion cycle itself; read data bypasses the hold
  // register during that cycle so there is no extra latency.
  always_comb begin
    if_valid = (pend == PEND_IF);
    d_valid  = (pend == PEND_D);
    if_rdata = if_valid ? sram_rdata : if_hold;
    d_rdata  = d_valid ? sram_rdata : d_hold;
  end

`ifdef MEM_ARB_STATS_EN
  // Count cycles a port is requesting but loses arbitration, ignoring its
  // own completion cycle where req still refers to the finished access.
  always_ff @(posedge clk or posedge rstl) begin
    if (rstl) begin
      stat_if_wait <= '0;
      stat_d_wait  <= '0;
    end else begin
      if (if_req && (pend != PEND_IF) && !grant_if && (stat_if_wait != '1))
        stat_if_wait <= stat_if_wait + 32'd1;
      if (d_req && (pend != PEND_D) && !grant_d && (stat_d_wait != '1))
        stat_d_wait <= stat_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed testbench for mem_arbiter with a behavioural single-port SRAM
//   (byte writes, one-cycle registered read). Inputs change 1 ns after the
//   rising edge; outputs are sampled 1 ns later.

module tb_mem_arbiter;

  logic        clk;
  logic        rstl;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_r;
  logic [3:0]  d_w;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_wait;
  logic [31:0] stat_d_wait;
`endif

  logic        preload;
  logic [31:0] mem [0:4095];

  int errors;
  int checks;
  int if_grants;
  int d_grants;

  mem_arbiter #(.XLEN(32), .WORDS_LOG2(12)) dut (
    .clk        (clk),
    .rstl       (rstl),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_r        (d_r),
    .d_w        (d_w),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_wait (stat_if_wait),
    .stat_d_wait  (stat_d_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM; preload seeds the two words the directed steps use.
  always @(posedge clk) begin
    if (preload) begin
      mem[2] <= 32'h00A00093;
      mem[4] <= 32'h00000000;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    if_grants = 0;
    d_grants = 0;
    preload = 1'b1;
    sram_rdata = 32'h0;
    rstl = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h8;
    d_req = 1'b0;
    d_addr = 32'h0;
    d_r = 4'h0;
    d_w = 4'h0;
    d_wdata = 32'h0;

    // Reset state, with a fetch request present that must not issue.
    step();
    step();
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_d_valid", {31'h0, d_valid}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_sram_en", {31'h0, sram_en}, 32'h0);
    check("rst_sram_we", {28'h0, sram_we}, 32'h0);

    // Fetch only: grant at T, valid at T+1, next grant at T+2.
    rstl = 1'b0;
    preload = 1'b0;
    settle();
    check("fetch_T_en", {31'h0, sram_en}, 32'h1);
    check("fetch_T_addr", {20'h0, sram_addr}, 32'd2);
    check("fetch_T_we", {28'h0, sram_we}, 32'h0);
    check("fetch_T_valid", {31'h0, if_valid}, 32'h0);
    step();
    check("fetch_T1_valid", {31'h0, if_valid}, 32'h1);
    check("fetch_T1_rdata", if_rdata, 32'h00A00093);
    check("fetch_T1_en", {31'h0, sram_en}, 32'h0);
    step();
    check("fetch_T2_en", {31'h0, sram_en}, 32'h1);
    check("fetch_T2_valid", {31'h0, if_valid}, 32'h0);
    check("fetch_T2_hold", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    settle();
    check("fetch_drop_en", {31'h0, sram_en}, 32'h0);

    // Data request with no strobes is not eligible.
    step();
    d_req = 1'b1;
    d_addr = 32'h10;
    settle();
    check("d_nostrobe_en", {31'h0, sram_en}, 32'h0);

    // Data write of the low two lanes.
    d_w = 4'b0011;
    d_wdata = 32'h0000FC18;
    settle();
    check("dw_en", {31'h0, sram_en}, 32'h1);
    check("dw_we", {28'h0, sram_we}, 32'h3);
    check("dw_addr", {20'h0, sram_addr}, 32'd4);
    check("dw_wdata", sram_wdata, 32'h0000FC18);
    step();
    check("dw_valid", {31'h0, d_valid}, 32'h1);
    check("dw_T1_en", {31'h0, sram_en}, 32'h0);

    // Read back the same word.
    step();
    d_w = 4'b0000;
    d_r = 4'b1111;
    settle();
    check("dr_en", {31'h0, sram_en}, 32'h1);
    check("dr_we", {28'h0, sram_we}, 32'h0);
    step();
    check("dr_valid", {31'h0, d_valid}, 32'h1);
    check("dr_rdata", d_rdata, 32'h0000FC18);
    d_req = 1'b0;
    d_r = 4'b0000;

    // Read and write strobes together act as a write to lane 2.
    step();
    d_req = 1'b1;
    d_r = 4'b1111;
    d_w = 4'b0100;
    d_wdata = 32'h00AB0000;
    settle();
    check("drw_we", {28'h0, sram_we}, 32'h4);
    step();
    check("drw_valid", {31'h0, d_valid}, 32'h1);
    step();
    d_w = 4'b0000;
    settle();
    step();
    check("drw_readback", d_rdata, 32'h00ABFC18);
    d_req = 1'b0;
    d_r = 4'b0000;

    // Contention: both rise together; data first, fetch next.
    step();
    if_req = 1'b1;
    if_addr = 32'h8;
    d_req = 1'b1;
    d_r = 4'b1111;
    d_addr = 32'h10;
    settle();
    check("cont_T_addr", {20'h0, sram_addr}, 32'd4);
    check("cont_T_en", {31'h0, sram_en}, 32'h1);
    step();
    check("cont_T1_dvalid", {31'h0, d_valid}, 32'h1);
    check("cont_T1_ifvalid", {31'h0, if_valid}, 32'h0);
    check("cont_T1_addr", {20'h0, sram_addr}, 32'd2);
    d_req = 1'b0;
    step();
    check("cont_T2_ifvalid", {31'h0, if_valid}, 32'h1);
    check("cont_T2_rdata", if_rdata, 32'h00A00093);
    check("cont_T2_dvalid", {31'h0, d_valid}, 32'h0);
`ifdef MEM_ARB_STATS_EN
    check("stat_if_wait", stat_if_wait, 32'd1);
    check("stat_d_wait", stat_d_wait, 32'd0);
`endif
    if_req = 1'b0;
    step();

    // Ping-pong: both held for 8 cycles, strict alternation starting with data.
    if_req = 1'b1;
    d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("pp_en", {31'h0, sram_en}, 32'h1);
      check("pp_addr", {20'h0, sram_addr}, (k % 2 == 0) ? 32'd4 : 32'd2);
      if (sram_en && sram_addr == 12'd4) d_grants++;
      if (sram_en && sram_addr == 12'd2) if_grants++;
      step();
    end
    check("pp_d_grants", d_grants, 32'd4);
    check("pp_if_grants", if_grants, 32'd4);
    check("pp_last_ifvalid", {31'h0, if_valid}, 32'h1);
    if_req = 1'b0;
    d_req = 1'b0;
    d_r = 4'b0000;
    step();

    // Reset the cycle after a fetch grant drops the in-flight read.
    if_req = 1'b1;
    settle();
    check("rr_grant_en", {31'h0, sram_en}, 32'h1);
    step();
    rstl = 1'b1;
    settle();
    check("rr_ifvalid", {31'h0, if_valid}, 32'h0);
    check("rr_ifrdata", if_rdata, 32'h0);
    check("rr_en", {31'h0, sram_en}, 32'h0);
    step();
    rstl = 1'b0;
    settle();
    check("rr_reissue_en", {31'h0, sram_en}, 32'h1);
    step();
    check("rr_reissue_valid", {31'h0, if_valid}, 32'h1);
    check("rr_reissue_rdata", if_rdata, 32'h00A00093);
    if_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
